// File: rtl/regfile_mp.sv
// Multi-port register file: three combinational read ports, two write ports
// (port 1 wins on collision), optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 5,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          RST_INDEX = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] regA,
  input  logic [AW-1:0] regB,
  input  logic [AW-1:0] regC,
  output logic [DW-1:0] Adat,
  output logic [DW-1:0] Bdat,
  output logic [DW-1:0] Cdat,
  output logic          Abusy,
  output logic          Bbusy,
  output logic          Cbusy,
  input  logic          we0,
  input  logic [AW-1:0] regW0,
  input  logic [DW-1:0] Wdat0,
  input  logic          we1,
  input  logic [AW-1:0] regW1,
  input  logic [DW-1:0] Wdat1,
  input  logic          set_en,
  input  logic [AW-1:0] set_reg,
  output logic          any_busy
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0]    mem_q [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  logic [Depth-1:0] wsel0, wsel1, set_sel;

  function automatic logic [DW-1:0] rst_val(input int unsigned idx);
    if (RST_INDEX && (idx != 0)) return DW'(idx);
    return '0;
  endfunction

  // One-hot write/set decodes; entry 0 is never selected.
  always_comb begin
    wsel0   = '0;
    wsel1   = '0;
    set_sel = '0;
    for (int unsigned i = 1; i < Depth; i++) begin
      wsel0[i]   = we0 && (regW0 == AW'(i));
      wsel1[i]   = we1 && (regW1 == AW'(i));
      set_sel[i] = set_en && (set_reg == AW'(i));
    end
  end

  // A new load issued in the same cycle as a return keeps the register busy.
  always_comb begin
    busy_d = (busy_q & ~wsel1) | set_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= rst_val(i);
      end
    end else begin
      for (int unsigned i = 1; i < Depth; i++) begin
        if (wsel1[i]) begin
          mem_q[i] <= Wdat1;
        end else if (wsel0[i]) begin
          mem_q[i] <= Wdat0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Bypass is suppressed during reset so reads show the reset contents.
  logic byp_en;
  assign byp_en = BYPASS && !rst;

  logic [AW-1:0] raddr [3];
  logic [DW-1:0] rdata [3];
  logic          rbusy [3];

  assign raddr[0] = regA;
  assign raddr[1] = regB;
  assign raddr[2] = regC;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      if (raddr[p] != '0) begin
        rbusy[p] = busy_q[raddr[p]];
        if (byp_en && we1 && (regW1 == raddr[p])) begin
          rdata[p] = Wdat1;
        end else if (byp_en && we0 && (regW0 == raddr[p])) begin
          rdata[p] = Wdat0;
        end else begin
          rdata[p] = mem_q[raddr[p]];
        end
      end
    end
  end

  assign Adat     = rdata[0];
  assign Bdat     = rdata[1];
  assign Cdat     = rdata[2];
  assign Abusy    = rbusy[0];
  assign Bbusy    = rbusy[1];
  assign Cbusy    = rbusy[2];
  assign any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, reset/narrow-instance sequences and
// randomized traffic against an array-based reference model.
module tb_regfile_mp;

  logic        clk, rst;
  logic [4:0]  regA, regB, regC, regW0, regW1, set_reg;
  logic [31:0] Wdat0, Wdat1;
  logic        we0, we1, set_en;

  logic [31:0] b_Adat, b_Bdat, b_Cdat, n_Adat, n_Bdat, n_Cdat;
  logic        b_Abusy, b_Bbusy, b_Cbusy, b_any;
  logic        n_Abusy, n_Bbusy, n_Cbusy, n_any;

  logic [2:0]  s_regA, s_regW0;
  logic [15:0] s_Wdat0, s_Adat, s_Bdat, s_Cdat;
  logic        s_we0, s_Abusy, s_Bbusy, s_Cbusy, s_any;

  int n_vec = 0;
  int n_bad = 0;

  regfile_mp #(.DW(32), .AW(5), .BYPASS(1'b1), .RST_INDEX(1'b1)) u_byp (
    .clk(clk), .rst(rst), .regA(regA), .regB(regB), .regC(regC),
    .Adat(b_Adat), .Bdat(b_Bdat), .Cdat(b_Cdat),
    .Abusy(b_Abusy), .Bbusy(b_Bbusy), .Cbusy(b_Cbusy),
    .we0(we0), .regW0(regW0), .Wdat0(Wdat0), .we1(we1), .regW1(regW1), .Wdat1(Wdat1),
    .set_en(set_en), .set_reg(set_reg), .any_busy(b_any)
  );

  regfile_mp #(.DW(32), .AW(5), .BYPASS(1'b0), .RST_INDEX(1'b1)) u_nobyp (
    .clk(clk), .rst(rst), .regA(regA), .regB(regB), .regC(regC),
    .Adat(n_Adat), .Bdat(n_Bdat), .Cdat(n_Cdat),
    .Abusy(n_Abusy), .Bbusy(n_Bbusy), .Cbusy(n_Cbusy),
    .we0(we0), .regW0(regW0), .Wdat0(Wdat0), .we1(we1), .regW1(regW1), .Wdat1(Wdat1),
    .set_en(set_en), .set_reg(set_reg), .any_busy(n_any)
  );

  regfile_mp #(.DW(16), .AW(3), .BYPASS(1'b1), .RST_INDEX(1'b1)) u_small (
    .clk(clk), .rst(rst), .regA(s_regA), .regB(3'd0), .regC(3'd0),
    .Adat(s_Adat), .Bdat(s_Bdat), .Cdat(s_Cdat),
    .Abusy(s_Abusy), .Bbusy(s_Bbusy), .Cbusy(s_Cbusy),
    .we0(s_we0), .regW0(s_regW0), .Wdat0(s_Wdat0), .we1(1'b0), .regW1(3'd0), .Wdat1(16'd0),
    .set_en(1'b0), .set_reg(3'd0), .any_busy(s_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    we0 = 0; regW0 = 0; Wdat0 = 0; we1 = 0; regW1 = 0; Wdat1 = 0;
    set_en = 0; set_reg = 0; regA = 0; regB = 0; regC = 0;
  endtask

  // Reference model: plain arrays updated from the write/scoreboard rules.
  logic [31:0] ref_mem [32];
  bit          ref_busy [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ref_mem[i]  = i;
      ref_busy[i] = 0;
    end
  endtask

  task automatic model_clock();
    if (we0 && regW0 != 0) ref_mem[regW0] = Wdat0;
    if (we1 && regW1 != 0) ref_mem[regW1] = Wdat1;
    if (we1 && regW1 != 0) ref_busy[regW1] = 0;
    if (set_en && set_reg != 0) ref_busy[set_reg] = 1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && we1 && regW1 == a) return Wdat1;
    if (byp && we0 && regW0 == a) return Wdat0;
    return ref_mem[a];
  endfunction

  function automatic bit exp_any();
    for (int i = 0; i < 32; i++) if (ref_busy[i]) return 1;
    return 0;
  endfunction

  typedef struct {
    logic        we0;  logic [4:0] w0; logic [31:0] d0;
    logic        we1;  logic [4:0] w1; logic [31:0] d1;
    logic        se;   logic [4:0] sr;
    logic [4:0]  ra;   logic [4:0] rb;
    logic [31:0] ea_b; logic [31:0] ea_n;
    logic        ea_busy; logic eb_busy; logic e_any;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{0, 0, 32'h0,        0, 0,  32'h0,  0, 0,  3,  9,  32'h3,  32'h3,  0, 0, 0};
    tbl[1] = '{1, 0, 32'hDEADBEEF, 0, 0,  32'h0,  1, 0,  0,  0,  32'h0,  32'h0,  0, 0, 0};
    tbl[2] = '{0, 0, 32'h0,        0, 0,  32'h0,  0, 0,  0,  0,  32'h0,  32'h0,  0, 0, 0};
    tbl[3] = '{1, 7, 32'h11,       1, 7,  32'h22, 1, 9,  7,  9,  32'h22, 32'h7,  0, 0, 0};
    tbl[4] = '{1, 9, 32'h33,       0, 0,  32'h0,  0, 0,  7,  9,  32'h22, 32'h22, 0, 1, 1};
    tbl[5] = '{0, 0, 32'h0,        1, 9,  32'h55, 0, 0,  9,  9,  32'h55, 32'h33, 1, 1, 1};
    tbl[6] = '{0, 0, 32'h0,        1, 12, 32'hAB, 1, 12, 9,  9,  32'h55, 32'h55, 0, 0, 0};
    tbl[7] = '{0, 0, 32'h0,        0, 0,  32'h0,  0, 0,  12, 12, 32'hAB, 32'hAB, 1, 1, 1};
    tbl[8] = '{0, 0, 32'h0,        1, 12, 32'h01, 0, 0,  12, 12, 32'h01, 32'hAB, 1, 1, 1};
    tbl[9] = '{0, 0, 32'h0,        0, 0,  32'h0,  0, 0,  12, 12, 32'h01, 32'h01, 0, 0, 0};

    idle_inputs();
    s_regA = 0; s_regW0 = 0; s_Wdat0 = 0; s_we0 = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Narrow instance: reset contents, then a single full-scale write to reg 7.
    for (int i = 0; i < 8; i++) begin
      s_regA = 3'(i);
      #1 chk($sformatf("small_rst_r%0d", i), {16'h0, s_Adat}, i);
    end
    @(posedge clk); #1;
    s_we0 = 1; s_regW0 = 3'd7; s_Wdat0 = 16'hFFFF; s_regA = 3'd7;
    @(negedge clk);
    chk("small_bypass_r7", {16'h0, s_Adat}, 32'hFFFF);
    @(posedge clk); #1;
    s_we0 = 0;
    for (int i = 0; i < 8; i++) begin
      s_regA = 3'(i);
      #1 chk($sformatf("small_after_r%0d", i), {16'h0, s_Adat}, (i == 7) ? 32'hFFFF : i);
    end

    // Directed table from the reset state.
    for (int r = 0; r < 10; r++) begin
      we0 = tbl[r].we0; regW0 = tbl[r].w0; Wdat0 = tbl[r].d0;
      we1 = tbl[r].we1; regW1 = tbl[r].w1; Wdat1 = tbl[r].d1;
      set_en = tbl[r].se; set_reg = tbl[r].sr;
      regA = tbl[r].ra; regB = tbl[r].rb; regC = tbl[r].ra;
      @(negedge clk);
      chk($sformatf("tbl%0d_Adat_byp", r),   b_Adat,  tbl[r].ea_b);
      chk($sformatf("tbl%0d_Cdat_byp", r),   b_Cdat,  tbl[r].ea_b);
      chk($sformatf("tbl%0d_Adat_nobyp", r), n_Adat,  tbl[r].ea_n);
      chk($sformatf("tbl%0d_Abusy", r),      b_Abusy, tbl[r].ea_busy);
      chk($sformatf("tbl%0d_Bbusy", r),      b_Bbusy, tbl[r].eb_busy);
      chk($sformatf("tbl%0d_any_busy", r),   b_any,   tbl[r].e_any);
      @(posedge clk); #1;
    end

    // Mid-cycle reset overriding a pending write and a busy bit.
    idle_inputs();
    set_en = 1; set_reg = 20;
    @(posedge clk); #1;
    idle_inputs();
    we0 = 1; regW0 = 5; Wdat0 = 32'h99; regA = 5; regB = 20;
    #1;
    chk("prerst_Adat_byp",   b_Adat,  32'h99);
    chk("prerst_Adat_nobyp", n_Adat,  32'h5);
    chk("prerst_Bbusy",      b_Bbusy, 1);
    chk("prerst_any",        b_any,   1);
    rst = 1'b1;
    #1;
    chk("inrst_Adat_byp",   b_Adat,  32'h5);
    chk("inrst_Adat_nobyp", n_Adat,  32'h5);
    chk("inrst_Bbusy",      b_Bbusy, 0);
    chk("inrst_any",        b_any,   0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    we0 = 0;
    model_reset();
    @(posedge clk); #1;
    chk("postrst_Adat", b_Adat, 32'h5);
    chk("postrst_any",  b_any,  0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      we0 = 1'($urandom); we1 = 1'($urandom); set_en = 1'($urandom_range(0, 2) == 0);
      regW0   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      regW1   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      set_reg = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      regA    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      regB    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      regC    = 5'($urandom);
      Wdat0 = $urandom; Wdat1 = $urandom;
      @(negedge clk);
      chk("rnd_Adat_byp",   b_Adat,  exp_rd(regA, 1));
      chk("rnd_Bdat_byp",   b_Bdat,  exp_rd(regB, 1));
      chk("rnd_Cdat_byp",   b_Cdat,  exp_rd(regC, 1));
      chk("rnd_Adat_nobyp", n_Adat,  exp_rd(regA, 0));
      chk("rnd_Bdat_nobyp", n_Bdat,  exp_rd(regB, 0));
      chk("rnd_Cdat_nobyp", n_Cdat,  exp_rd(regC, 0));
      chk("rnd_Abusy",      b_Abusy, ref_busy[regA]);
      chk("rnd_Bbusy",      b_Bbusy, ref_busy[regB]);
      chk("rnd_Cbusy",      n_Cbusy, ref_busy[regC]);
      chk("rnd_any_byp",    b_any,   exp_any());
      chk("rnd_any_nobyp",  n_any,   exp_any());
      @(posedge clk);
      model_clock();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the next generation of the CPU's 32x32 register file. It provides three asynchronous read ports (A, B, C) and two synchronous write ports: W0 for ALU/writeback and W1 for the load/multi-cycle return path. It adds optional write-to-read bypass and a per-register busy scoreboard, so the pipeline can detect pending multi-cycle results. It sits in the decode stage, between the instruction decoder and the hazard/forwarding unit.

Parameters:
DW, 32, data width of each register
AW, 5, register address width; depth = 2**AW entries
BYPASS, 1, 1 = a read of a register being written this cycle returns the incoming write data; 0 = it returns the stored value
RST_INDEX, 1, 1 = register i resets to i (truncated to DW); 0 = all registers reset to 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
regA  in  AW  read address A
regB  in  AW  read address B
regC  in  AW  read address C
Adat  out  DW  read data A
Bdat  out  DW  read data B
Cdat  out  DW  read data C
Abusy  out  1  scoreboard busy bit of regA
Bbusy  out  1  scoreboard busy bit of regB
Cbusy  out  1  scoreboard busy bit of regC
we0  in  1  write enable, port 0
regW0  in  AW  write address, port 0
Wdat0  in  DW  write data, port 0
we1  in  1  write enable, port 1 (load return); clears the busy bit
regW1  in  AW  write address, port 1
Wdat1  in  DW  write data, port 1
set_en  in  1  mark register set_reg busy (load issued)
set_reg  in  AW  register to mark busy
any_busy  out  1  OR of all busy bits

Behaviour:
- Storage: 2**AW x DW flops plus 2**AW busy flops, all on posedge clk or posedge rst.
- Reset: asynchronous, takes effect immediately, and overrides any in-progress write. Register i is loaded with i (RST_INDEX=1) or 0; register 0 is always 0. All busy bits clear, so any_busy=0. Read outputs follow the reset contents combinationally.
- Register 0: writes to it are discarded and its busy bit is never set. Reading it gives 0 and busy 0, regardless of BYPASS.
- Writes: when weN=1 and regWN!=0, the register takes WdatN at the next rising edge.
  - If we0 and we1 target the same register in the same cycle, port 1 wins.
- Reads: combinational, with zero-cycle latency.
  - BYPASS=1: if a read address matches an active write address (non-zero), output that write data. Port 1 takes priority over port 0, matching the write priority.
  - BYPASS=0: output the stored value; the new value appears the cycle after the edge.
- Scoreboard, per register r != 0, at each rising edge:
  - set_en && set_reg==r sets busy[r].
  - Otherwise, we1 && regW1==r clears busy[r].
  - A simultaneous set and clear of the same register leaves it set, because a new load was issued.
  - we0 never affects busy.
  - set_en on a register that is already busy keeps it busy (no counting).
- Busy outputs reflect registered state only; there is no bypass of set or clear.
- any_busy is combinational from the busy flops.
- There are no other state machines; the scoreboard is one 2-state (idle/busy) FSM per register.

Test Plan:
- Assert rst mid-cycle while we0=1, regW0=5 -> Adat for regA=5 reads 5 immediately (RST_INDEX=1); after release, the write is lost and any_busy=0.
- we0=1, regW0=0, Wdat0=0xDEADBEEF, then read regA=0 -> Adat=0, Abusy=0; the same holds for set_en on reg 0.
- BYPASS=1: we0=1, regW0=7, Wdat0=0x11 and we1=1, regW1=7, Wdat1=0x22, with regA=7 in the same cycle -> Adat=0x22 that cycle and 0x22 after the edge. With BYPASS=0 -> Adat=7 that cycle, 0x22 after the edge.
- set_en with set_reg=9 -> Bbusy=1 (regB=9) next cycle and any_busy=1. Then we1 on reg 9 with Wdat1=0x55 -> Bbusy=0 and Bdat=0x55 after that edge; we0 on reg 9 in between leaves Bbusy=1.
- In one cycle, set_en with set_reg=12 and we1 with regW1=12 -> busy[12] stays 1 and the register holds Wdat1.
- DW=16, AW=3 instance: reset gives registers 0..7 = index. A write to reg 7 with 0xFFFF reads back 0xFFFF, and no other register changes.
